sram_dp_arbiter: RTL

SRAM_DP_ARBITER -- requirements
Module: sram_dp_arbiter

---
 rtl/sram_dp_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sram_dp_arbiter.sv
// Three-requester arbiter in front of a dual-port SRAM with rotating priority and 1-cycle read return.
// Optional macro SRAM_ARB_ADDR_CONFLICT_EN stalls the second request on a same-address write hazard.
module sram_dp_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [2:0]              i_req,
  input  logic [2:0]              i_rdwr_n,
  input  logic [3*ADDR_WIDTH-1:0] i_addr,
  input  logic [3*WIDTH-1:0]      i_wdata,
  output logic [2:0]              o_gnt,
  output logic [2:0]              o_rvalid,
  output logic [3*WIDTH-1:0]      o_rdata,
  output logic                    o_ce_n,
  output logic                    o_rdwr_n_0,
  output logic                    o_rdwr_n_1,
  output logic [ADDR_WIDTH-1:0]   o_addr_0,
  output logic [ADDR_WIDTH-1:0]   o_addr_1,
  output logic [WIDTH-1:0]        o_data_0,
  output logic [WIDTH-1:0]        o_data_1,
  input  logic [WIDTH-1:0]        i_data_0,
  input  logic [WIDTH-1:0]        i_data_1
);

  // Handshake: a requester holds i_req with stable rdwr_n/addr/wdata until it sees
  // o_gnt in the same cycle; the transfer happens on the next rising edge.
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            tag_v_q, tag_v_d;
  logic [1:0]            tag_id0_q, tag_id0_d;
  logic [1:0]            tag_id1_q, tag_id1_d;
  logic                  sel0_v, sel1_v;
  logic [1:0]            sel0_id, sel1_id;
  logic                  g0, g1;
  logic [1:0]            cand [3];
  logic [ADDR_WIDTH-1:0] req_addr [3];
  logic [WIDTH-1:0]      req_wdata [3];

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      req_addr[r]  = i_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      req_wdata[r] = i_wdata[r*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) begin
      s = int'(ptr_q) + k;
      if (s >= 3) s = s - 3;
      cand[k] = 2'(s);
    end
  end

  // First two active requesters in rotation order take ports 0 and 1.
  always_comb begin
    sel0_v  = 1'b0;
    sel1_v  = 1'b0;
    sel0_id = 2'd0;
    sel1_id = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (i_req[cand[k]]) begin
        if (!sel0_v) begin
          sel0_v  = 1'b1;
          sel0_id = cand[k];
        end else if (!sel1_v) begin
          sel1_v  = 1'b1;
          sel1_id = cand[k];
        end
      end
    end
`ifdef SRAM_ARB_ADDR_CONFLICT_EN
    if (sel0_v && sel1_v && (req_addr[sel0_id] == req_addr[sel1_id]) &&
        !(i_rdwr_n[sel0_id] && i_rdwr_n[sel1_id])) begin
      sel1_v = 1'b0;
    end
`endif
  end

  assign g0 = sel0_v & i_rst_n;
  assign g1 = sel1_v & i_rst_n;

  always_comb begin
    o_gnt = 3'b000;
    if (g0) o_gnt[sel0_id] = 1'b1;
    if (g1) o_gnt[sel1_id] = 1'b1;
    o_ce_n     = ~(g0 | g1);
    o_rdwr_n_0 = 1'b1;
    o_addr_0   = '0;
    o_data_0   = '0;
    o_rdwr_n_1 = 1'b1;
    o_addr_1   = '0;
    o_data_1   = '0;
    if (g0) begin
      o_rdwr_n_0 = i_rdwr_n[sel0_id];
      o_addr_0   = req_addr[sel0_id];
      o_data_0   = req_wdata[sel0_id];
    end
    if (g1) begin
      o_rdwr_n_1 = i_rdwr_n[sel1_id];
      o_addr_1   = req_addr[sel1_id];
      o_data_1   = req_wdata[sel1_id];
    end
  end

  // Returning data is steered by the tag captured when the read was granted.
  always_comb begin
    o_rvalid = 3'b000;
    o_rdata  = '0;
    if (tag_v_q[0]) begin
      o_rvalid[tag_id0_q]                 = 1'b1;
      o_rdata[tag_id0_q*WIDTH +: WIDTH]   = i_data_0;
    end
    if (tag_v_q[1]) begin
      o_rvalid[tag_id1_q]                 = 1'b1;
      o_rdata[tag_id1_q*WIDTH +: WIDTH]   = i_data_1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (g1)      ptr_d = inc3(sel1_id);
    else if (g0) ptr_d = inc3(sel0_id);
    tag_v_d   = {g1 & i_rdwr_n[sel1_id], g0 & i_rdwr_n[sel0_id]};
    tag_id0_d = sel0_id;
    tag_id1_d = sel1_id;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q     <= 2'd0;
      tag_v_q   <= 2'b00;
      tag_id0_q <= 2'd0;
      tag_id1_q <= 2'd0;
    end else begin
      ptr_q     <= ptr_d;
      tag_v_q   <= tag_v_d;
      tag_id0_q <= tag_id0_d;
      tag_id1_q <= tag_id1_d;
    end
  end

endmodule
